// File: rtl/digi_ota_pkg.sv
// Shared types and defaults for the OTA offset-calibration sequencer.
package digi_ota_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DECIDE = 2'd3
    } cal_state_t;

    localparam int TRIM_W_DEF     = 6;
    localparam int SETTLE_CYC_DEF = 4;
    localparam int VOTES_DEF      = 3;

    // Mid-scale trim code: only the MSB set.
    function automatic int mid_code(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/digi_ota_cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output, reset to 0.
module digi_ota_cmp_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/digi_ota_cal_ctrl.sv
// SAR offset-trim sequencer: settle, majority-vote the comparator, decide one
// trim bit per step, then freeze the code and enable the OTA output buffer.
module digi_ota_cal_ctrl
    import digi_ota_pkg::*;
#(
    parameter int TRIM_W     = TRIM_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int VOTES      = VOTES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_cmp_out,
    output logic [TRIM_W-1:0] o_trim,
    output logic              o_cal_mode,
    output logic              o_out_en,
    output logic              o_busy,
    output logic              o_done
);

    localparam int IDX_W  = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam int VOTE_W = $clog2(VOTES + 1);
    localparam int CNT_MAX = (SETTLE_CYC > VOTES) ? SETTLE_CYC : VOTES;
    localparam int CNT_W  = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [TRIM_W-1:0] MID         = TRIM_W'(mid_code(TRIM_W));
    localparam logic [IDX_W-1:0]  IDX_TOP     = IDX_W'(TRIM_W - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(VOTES - 1);
    localparam logic [VOTE_W-1:0] MAJORITY    = VOTE_W'((VOTES + 1) / 2);

    cal_state_t        r_state;
    logic [TRIM_W-1:0] r_trim;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [VOTE_W-1:0] r_votes;
    logic              r_cal_mode;
    logic              r_out_en;
    logic              r_busy;
    logic              r_done;
    logic              w_cmp_s;

    digi_ota_cmp_sync u_cmp_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_cmp_out),
        .o_q   (w_cmp_s)
    );

    // r_cnt is shared: settle cycles in SETTLE, samples taken in SAMPLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_trim     <= MID;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_votes    <= '0;
            r_cal_mode <= 1'b0;
            r_out_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (i_abort && (r_state != ST_IDLE)) begin
            r_state    <= ST_IDLE;
            r_trim     <= MID;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_votes    <= '0;
            r_cal_mode <= 1'b0;
            r_out_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_state    <= ST_SETTLE;
                        r_idx      <= IDX_TOP;
                        r_trim     <= MID;
                        r_cnt      <= '0;
                        r_votes    <= '0;
                        r_cal_mode <= 1'b1;
                        r_out_en   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    r_votes <= r_votes + VOTE_W'(w_cmp_s);
                    if (r_cnt == SAMPLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_DECIDE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DECIDE: begin
                    r_votes <= '0;
                    // Comparator high means trim too low: keep the trial bit.
                    if (r_votes < MAJORITY) begin
                        r_trim[r_idx] <= 1'b0;
                    end
                    if (r_idx != '0) begin
                        r_trim[r_idx - IDX_W'(1)] <= 1'b1;
                        r_idx   <= r_idx - IDX_W'(1);
                        r_state <= ST_SETTLE;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_cal_mode <= 1'b0;
                        r_out_en   <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_trim     = r_trim;
    assign o_cal_mode = r_cal_mode;
    assign o_out_en   = r_out_en;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_digi_ota_cal_ctrl.sv
// Directed bench for the OTA calibration sequencer with a threshold OTA model
// and a queue of expected trial/final trim codes.
module tb_digi_ota_cal_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       cmp;
    logic [5:0] trim;
    logic       cal_mode;
    logic       out_en;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    digi_ota_cal_ctrl #(.TRIM_W(6), .SETTLE_CYC(4), .VOTES(3)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_abort    (abort),
        .i_cmp_out  (cmp),
        .o_trim     (trim),
        .o_cal_mode (cal_mode),
        .o_out_en   (out_en),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // OTA threshold model: comparator high while trim <= thr.
    function automatic logic model(input int thr, input logic [5:0] t);
        return (int'(t) <= thr);
    endfunction

    task automatic push_expected(input int thr);
        int code;
        int trial;
        code = 0;
        for (int b = 5; b >= 0; b--) begin
            trial = code | (1 << b);
            exp_q.push_back(trial);
            if (trial <= thr) code = trial;
        end
        exp_q.push_back(code);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_trim"}, trim, 32);
        chk({tag, "_cal_mode"}, cal_mode, 0);
        chk({tag, "_out_en"}, out_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic run_cal(input string tag, input int thr, input bit noise);
        int e;
        int fin;
        push_expected(thr);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        chk({tag, "_cal_mode_on"}, cal_mode, 1);
        chk({tag, "_done_clr"}, done, 0);
        e = 0;
        forever begin
            if ((e % 8 == 0) && (e < 48) && (exp_q.size() > 1))
                chk({tag, "_trial"}, trim, exp_q.pop_front());
            cmp = model(thr, trim) ^ (noise && (((e + 1) % 8) == 4));
            @(posedge clk);
            #1;
            e++;
            if (!busy) break;
            if (e >= 100) begin
                chk({tag, "_timeout"}, e, 48);
                break;
            end
        end
        fin = (exp_q.size() > 0) ? exp_q[$] : -1;
        exp_q.delete();
        chk({tag, "_busy_cycles"}, e, 48);
        chk({tag, "_final_trim"}, trim, fin);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_out_en"}, out_en, 1);
        chk({tag, "_cal_mode_off"}, cal_mode, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cmp = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // Nominal, rails, noise
        run_cal("nominal", 45, 1'b0);
        run_cal("rail_lo", -1, 1'b0);
        run_cal("rail_hi", 63, 1'b0);
        run_cal("noise", 45, 1'b1);

        // Abort at cycle 20 with ignored start pulses in between
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 0;
        while (e < 19) begin
            start = (e % 2 == 1);
            cmp = model(45, trim);
            @(posedge clk);
            #1;
            e++;
            if (e == 16) chk("abort_trial3", trim, 40);
        end
        chk("abort_busy_pre", busy, 1);
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("abort");
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("start_abort_idle_busy", busy, 0);
        chk("start_abort_idle_cal", cal_mode, 0);
        start = 1'b0;
        abort = 1'b0;

        // Mid-run reset at cycle 30, then two full re-calibrations
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 0;
        while (e < 29) begin
            cmp = model(45, trim);
            @(posedge clk);
            #1;
            e++;
        end
        chk("midrst_busy_pre", busy, 1);
        rst = 1'b1;
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("midrst");
        rst = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        run_cal("recal1", 45, 1'b0);
        run_cal("recal2", 45, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/digi_ota_cal_ctrl.md
# digi_ota_cal_ctrl

Offset-calibration sequencer for the digital OTA core. At power-up or on request, it runs a successive-approximation (SAR) search over the OTA's offset-trim DAC code. During the search it holds the OTA in calibration mode, with inputs shorted and the tristate output buffer disabled. After the search it freezes the trim and enables the output buffer. It sits between the chip's digital control inputs and the OTA's trim/enable pins.

## Interface

Parameters:
- `TRIM_W`, 6: trim code width; SAR runs `TRIM_W` bit-steps.
- `SETTLE_CYC`, 4: cycles waited after each trial code before sampling; must be ≥2 (covers the synchronizer).
- `VOTES`, 3: comparator samples per bit; must be odd and ≥1.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  level-sampled; starts calibration when high in IDLE.
- `abort`  in  1  level-sampled; cancels calibration.
- `cmp_out`  in  1  OTA comparator output; asynchronous; high means the trim is too low.
- `trim`  out  `TRIM_W`  trim code to the OTA offset DAC.
- `cal_mode`  out  1  high while calibrating; shorts the OTA inputs.
- `out_en`  out  1  drives the OTA output tristate enable.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  sticky; high after a successful calibration.

## Operation

- Reset values: `trim` = `1<<(TRIM_W-1)` (mid-code), `cal_mode` = 0, `out_en` = 0, `busy` = 0, `done` = 0. The FSM is in IDLE, and the bit index and vote counter are 0.
- `cmp_out` passes through a 2-flop synchronizer (`cmp_s`) before any use.
- States:
  - **IDLE**: waits for `start`.
  - **SETTLE**: counts `SETTLE_CYC` cycles.
  - **SAMPLE**: for `VOTES` cycles, adds `cmp_s` to the vote counter.
  - **DECIDE**: takes one cycle to apply the bit decision.
- IDLE→SETTLE on `start`=1 and `abort`=0. On this transition:
  - bit index = `TRIM_W-1`;
  - `trim` = `1<<(TRIM_W-1)`;
  - result register cleared;
  - `cal_mode` = 1, `out_en` = 0, `done` = 0.
- SETTLE→SAMPLE when the settle count reaches `SETTLE_CYC`. SAMPLE→DECIDE after `VOTES` samples.
- DECIDE:
  - If votes ≥ `(VOTES+1)/2`, the current bit stays 1; otherwise it is cleared.
  - The vote counter is cleared.
  - If bit index > 0: set the next lower bit in `trim`, decrement the index, and go to SETTLE.
  - If bit index = 0: go to IDLE with `cal_mode` = 0, `out_en` = 1, `done` = 1. `trim` holds the final code.
- `abort`=1 in any non-IDLE state takes the FSM to IDLE on the next edge with `trim` = mid-code, `cal_mode` = 0, `out_en` = 0, `done` = 0. In IDLE, `abort` has no effect, and it takes priority over `start` when both are high.
- `start` while busy is ignored. `start` held high after completion restarts calibration; this is a legal re-calibration.
- Vote counter width is `$clog2(VOTES+1)` and it cannot overflow. Trim arithmetic uses bit set/clear only; there is no add or subtract.

## Timing

- All outputs are registered and change only on `clk` rising edges.
- If `start` is sampled at edge 0, `busy` and `cal_mode` are high after edge 0.
- Each bit-step takes exactly `SETTLE_CYC + VOTES + 1` cycles. The total busy time is `TRIM_W*(SETTLE_CYC+VOTES+1)` cycles; with defaults that is 48.
- `done`, `out_en`, and the final `trim` all become valid on the same edge that `busy` falls.
- The sampled comparator reflects `cmp_out` 2 cycles late. The `SETTLE_CYC` ≥ 2 minimum guarantees that samples reflect the current trial code.
- `rst` mid-operation returns every output to its reset value on the next edge, overriding `abort` and `start`.

## Structure

- Package `digi_ota_pkg`:
  - state enum `cal_state_t` (IDLE, SETTLE, SAMPLE, DECIDE);
  - default parameter constants;
  - a mid-code function.
- Sub-module `digi_ota_cmp_sync`: 2-flop synchronizer with reset-to-0, instantiated once for `cmp_out`.
- Top level: FSM, settle counter, vote counter, bit index, and the trim/result register.

## Test plan

Defaults throughout: `TRIM_W`=6, `SETTLE_CYC`=4, `VOTES`=3.

1. **Reset:** assert `rst` 2 cycles → `trim`=32, and `cal_mode`, `out_en`, `busy`, `done` all 0.
2. **Nominal search:** OTA model `cmp_out` = (`trim` ≤ 45), pulse `start` → trial codes 32, 48, 40, 44, 46, 45; final `trim`=45. `busy` high exactly 48 cycles, then `done`=1 and `out_en`=1.
3. **Rail cases:** `cmp_out` stuck 0 → final `trim`=0. `cmp_out` stuck 1 → final `trim`=63. Both reach `done`=1.
4. **Noise:** model from scenario 2, with one of the three votes inverted in every SAMPLE window → final `trim` still 45.
5. **Abort:** `abort` at cycle 20 of calibration → next edge IDLE, `trim`=32, `done`=0, `out_en`=0. `start` pulses during cycles 1–19 are ignored; `start` and `abort` high together in IDLE → stays in IDLE.
6. **Mid-run reset and re-calibration:** `rst` at cycle 30 → reset values. A fresh `start` then completes normally to 45. A second `start` after `done` clears `done` and re-runs the full 48 cycles.
